fsm_input_conditioner: RTL

FSM_INPUT_CONDITIONER -- requirements
Module: fsm_input_conditioner

---
 rtl/fsm_input_conditioner.sv | 115 +++++++++++
 1 files changed

// File: rtl/fsm_input_conditioner.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fsm_input_conditioner: synchronize and debounce 3 buttons, issue one-hot cmds
// Rev 1.0
// -----------------------------------------------------------------------------
module fsm_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] btn_raw,
  output logic [2:0] user_input,
  output logic       cmd_valid,
  output logic [2:0] btn_stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  logic [2:0]       sync1_q;
  logic [2:0]       sync2_q;
  logic [2:0]       stable_q;
  logic [2:0]       stable_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  state_t           state_q;
  state_t           state_d;
  logic [2:0]       user_q;
  logic [2:0]       user_d;
  logic             cmd_valid_q;
  logic             cmd_valid_d;
  logic [2:0]       pri_cmd;

  // A level is accepted on the DEBOUNCE_CYCLES-th consecutive differing edge.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    pri_cmd = 3'b000;
    if (stable_q[2])      pri_cmd = 3'b100;
    else if (stable_q[1]) pri_cmd = 3'b010;
    else if (stable_q[0]) pri_cmd = 3'b001;
  end

  always_comb begin
    state_d     = state_q;
    user_d      = user_q;
    cmd_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (stable_q != 3'b000) begin
          state_d     = PRESSED;
          user_d      = pri_cmd;
          cmd_valid_d = 1'b1;
        end
      end
      PRESSED: begin
        state_d = HELD;
      end
      HELD: begin
        if (stable_q == 3'b000) begin
          state_d = IDLE;
          user_d  = 3'b000;
        end
      end
      default: begin
        state_d = IDLE;
        user_d  = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 3'b000;
      sync2_q     <= 3'b000;
      stable_q    <= 3'b000;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      state_q     <= IDLE;
      user_q      <= 3'b000;
      cmd_valid_q <= 1'b0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      state_q     <= state_d;
      user_q      <= user_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  assign user_input = user_q;
  assign cmd_valid  = cmd_valid_q;
  assign btn_stable = stable_q;

endmodule
`default_nettype wire
